// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Bits needed to count 0..v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned bits;
        int unsigned span;
        bits = 0;
        span = 1;
        while (span < v) begin
            span = span << 1;
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/div_sign_seq_if.sv
// Start/busy/done request and result bundle for the signed divider.
interface div_sign_seq_if #(
    parameter int unsigned W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;

    modport master (
        output start, a, b,
        input  busy, done, q, r, dz, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, dz, ovf
    );
endinterface

// File: rtl/sgn_mag.sv
// Conditional two's-complement negate; with neg tied to the sign bit it yields |x|.
module sgn_mag #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);
    assign y = neg ? W'(~x + W'(1)) : x;
endmodule

// File: rtl/div_sign_seq.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, then sign fix.
module div_sign_seq
    import div_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst,
    div_sign_seq_if.slave  s
);
    localparam int unsigned CW = clog2(W);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    state_t state, state_nxt;
    logic   accept_c, step_c, fix_c;

    logic          sign_a, sign_b;
    logic [W-1:0]  bmag;
    logic [W-1:0]  dvd;
    logic [W:0]    rem;
    logic [CW-1:0] cnt;
    logic          dz_pend, ovf_pend;

    logic         busy_r, done_r, dz_r, ovf_r;
    logic [W-1:0] q_r, r_r;

    logic [W-1:0] amag_c, bmag_c, qfix_c, rfix_c;
    logic [W+1:0] shifted_c, diff_c;
    logic         ge_c;

    sgn_mag #(.W(W)) u_abs_a (.x(s.a),         .neg(s.a[W-1]),       .y(amag_c));
    sgn_mag #(.W(W)) u_abs_b (.x(s.b),         .neg(s.b[W-1]),       .y(bmag_c));
    sgn_mag #(.W(W)) u_fix_q (.x(dvd),         .neg(sign_a ^ sign_b), .y(qfix_c));
    sgn_mag #(.W(W)) u_fix_r (.x(rem[W-1:0]),  .neg(sign_a),          .y(rfix_c));

    // One restoring step: shift next dividend bit into the partial remainder and trial-subtract.
    assign shifted_c = {rem, dvd[W-1]};
    assign diff_c    = shifted_c - (W+2)'(bmag);
    assign ge_c      = shifted_c >= (W+2)'(bmag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        step_c    = 1'b0;
        fix_c     = 1'b0;
        case (state)
            IDLE: begin
                if (s.start) begin
                    accept_c  = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                step_c = 1'b1;
                if (cnt == CW'(W-1)) state_nxt = FIX;
            end
            FIX: begin
                fix_c     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch and iteration datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            bmag     <= '0;
            dvd      <= '0;
            rem      <= '0;
            cnt      <= '0;
            dz_pend  <= 1'b0;
            ovf_pend <= 1'b0;
        end else if (accept_c) begin
            sign_a   <= s.a[W-1];
            sign_b   <= s.b[W-1];
            bmag     <= bmag_c;
            dvd      <= amag_c;
            rem      <= '0;
            cnt      <= '0;
            dz_pend  <= (s.b == '0);
            ovf_pend <= (s.a == MIN_NEG) && (s.b == '1);
        end else if (step_c) begin
            rem <= ge_c ? (W+1)'(diff_c) : (W+1)'(shifted_c);
            dvd <= {dvd[W-2:0], ge_c};
            cnt <= cnt + CW'(1);
        end
    end

    // Result registers hold until the next completion; done is a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            q_r    <= '0;
            r_r    <= '0;
            dz_r   <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            busy_r <= (state_nxt != IDLE);
            done_r <= fix_c;
            if (fix_c) begin
                q_r   <= dz_pend ? '1 : qfix_c;
                r_r   <= rfix_c;
                dz_r  <= dz_pend;
                ovf_r <= ovf_pend;
            end
        end
    end

    assign s.busy = busy_r;
    assign s.done = done_r;
    assign s.q    = q_r;
    assign s.r    = r_r;
    assign s.dz   = dz_r;
    assign s.ovf  = ovf_r;

endmodule
